// File: rtl/c_another_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ cSt producers share one registered output channel.
// The winner is chosen combinationally starting at the rotation pointer; the
// output register reloads on the same cycle it drains, so sustained throughput
// is one transfer per cycle.
// Optional build macro: C_ARB_GRANT_CNT_EN adds per-requester saturating grant counters.
//
// state | meaning
// EMPTY | output register holds nothing, out_vld=0
// FULL  | output register holds a payload, out_vld=1
module c_another_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 10,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      out_vld,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_rdy
`ifdef C_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stateT;

  stateT            state, stateNext;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] winner;
  logic [SRC_W:0]   scanIdx;
  logic             anyVld;
  logic             canLoad;
  logic             load;

  assign out_vld = (state == FULL);
  assign canLoad = (state == EMPTY) | (out_vld & out_rdy);
  assign load    = canLoad & anyVld & ~rst;

  // Winner search: first valid requester scanning ptr upward with wrap.
  always_comb begin
    anyVld  = 1'b0;
    winner  = '0;
    scanIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = {1'b0, ptr} + (SRC_W+1)'(k);
      if (scanIdx >= (SRC_W+1)'(NUM_REQ)) scanIdx = scanIdx - (SRC_W+1)'(NUM_REQ);
      if (!anyVld && req_vld[scanIdx[SRC_W-1:0]]) begin
        anyVld = 1'b1;
        winner = scanIdx[SRC_W-1:0];
      end
    end
  end

  // Accept only the winner, and only when the output register can take it.
  always_comb begin
    req_rdy = '0;
    if (load) req_rdy[winner] = 1'b1;
  end

  // Output register occupancy: a load wins over a drain in the same cycle.
  always_comb begin
    stateNext = state;
    if (load) stateNext = FULL;
    else if ((state == FULL) && out_rdy) stateNext = EMPTY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= stateNext;
  end

  // Payload capture and pointer rotation; both move only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_data <= req_data[int'(winner)*DATA_W +: DATA_W];
      out_src  <= winner;
      ptr      <= (winner == SRC_W'(NUM_REQ-1)) ? '0 : winner + SRC_W'(1);
    end
  end

`ifdef C_ARB_GRANT_CNT_EN
  // Per-requester saturating grant counters; observation only.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (req_vld[gi] && req_rdy[gi] && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
    end
    assign grant_cnt[gi*16 +: 16] = cnt;
  end
`endif

  // Protocol invariants.
  a_rdy_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_rdy));
  a_data_hold:  assert property (@(posedge clk) disable iff (rst)
                  (out_vld && !out_rdy) |=> $stable(out_data));

endmodule

// File: tb/tb_c_another_rr_arbiter.sv
// Directed bench for c_another_rr_arbiter with a cycle-level reference model.
module tb_c_another_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 10;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic            out_vld;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_rdy;
`ifdef C_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  c_another_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_data(out_data),
    .out_src(out_src), .out_rdy(out_rdy)
`ifdef C_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: occupancy, payload, source, pointer, grant counts.
  bit          mOn = 0;
  bit          mVld;
  logic [DW-1:0] mData;
  int          mSrc;
  int          mPtr;
  int          mCnt [N];

  function automatic int pickWinner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] expRdy();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = pickWinner(req_vld, mPtr);
    if (!rst && g >= 0 && (!mVld || out_rdy)) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      mVld = 0; mData = '0; mSrc = 0; mPtr = 0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
    end else begin
      g = pickWinner(req_vld, mPtr);
      if (g >= 0 && (!mVld || out_rdy)) begin
        mVld = 1; mSrc = g; mData = req_data[g*DW +: DW];
        mPtr = (g + 1) % N;
        if (mCnt[g] < 65535) mCnt[g]++;
      end else if (mVld && out_rdy) begin
        mVld = 0;
      end
    end
    mOn = 1;
  end

  always @(negedge clk) begin
    if (mOn) begin
      check("model_out_vld", out_vld, mVld);
      check("model_out_data", out_data, mData);
      check("model_out_src", out_src, mSrc);
      check("model_req_rdy", req_rdy, expRdy());
`ifdef C_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) check("model_grant_cnt", grant_cnt[i*16 +: 16], mCnt[i]);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int expSeq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; req_vld = 4'hF; out_rdy = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(10'h100 + i);
    step(2);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_req_rdy", req_rdy, 4'b0000);
    check("rst_out_data", out_data, 10'h000);
    rst = 1'b0; #1;
    check("first_grant_rdy", req_rdy, 4'b0001);

    // All busy: rotation 0,1,2,3,0,1 with no gaps.
    for (int c = 0; c < 6; c++) begin
      step(1);
      check("busy_vld", out_vld, 1'b1);
      check("busy_src", out_src, expSeq[c]);
      check("busy_data", out_data, 10'h100 + expSeq[c]);
    end
    req_vld = 4'b0000;
    step(1);
    check("drain_vld", out_vld, 1'b0);

    // Single requester 2 (pointer is at 2 now).
    req_vld = 4'b0100; req_data[2*DW +: DW] = 10'h155; #1;
    check("single_rdy", req_rdy, 4'b0100);
    step(1);
    req_vld = 4'b0000;
    check("single_vld", out_vld, 1'b1);
    check("single_data", out_data, 10'h155);
    check("single_src", out_src, 2);
    step(1);

    // Wrap from ptr=3 with requesters 3 and 0.
    req_vld = 4'b1001; #1;
    check("wrap_rdy3", req_rdy, 4'b1000);
    step(1);
    check("wrap_src3", out_src, 3);
    req_vld = 4'b0001; #1;
    check("wrap_rdy0", req_rdy, 4'b0001);
    step(1);
    check("wrap_src0", out_src, 0);
    req_vld = 4'b0010; #1;
    check("skip_rdy1", req_rdy, 4'b0010);
    step(1);
    check("skip_src1", out_src, 1);
    req_vld = 4'b0000;
    step(1);

    // Backpressure: ptr=2, requester 2 carries 3FF.
    req_data[2*DW +: DW] = 10'h3FF;
    req_vld = 4'hF; #1;
    check("bp_ptr2_rdy", req_rdy, 4'b0100);
    step(1);
    req_vld = 4'b1011; out_rdy = 1'b0;
    check("bp_load_data", out_data, 10'h3FF);
    for (int c = 0; c < 5; c++) begin
      step(1);
      check("bp_hold_data", out_data, 10'h3FF);
      check("bp_hold_vld", out_vld, 1'b1);
      check("bp_hold_rdy", req_rdy, 4'b0000);
    end
    out_rdy = 1'b1; #1;
    check("bp_release_rdy", req_rdy, 4'b1000);
    step(1);
    check("bp_next_src", out_src, 3);
    check("bp_next_data", out_data, 10'h103);
    check("bp_next_vld", out_vld, 1'b1);

    // Mid-transfer reset.
    out_rdy = 1'b0; req_vld = 4'hF;
    step(1);
    check("mid_pre_vld", out_vld, 1'b1);
    rst = 1'b1;
    step(1);
    check("mid_rst_vld", out_vld, 1'b0);
`ifdef C_ARB_GRANT_CNT_EN
    check("mid_rst_cnt", grant_cnt, '0);
`endif
    rst = 1'b0; out_rdy = 1'b1; #1;
    check("mid_rst_ptr0", req_rdy, 4'b0001);

`ifdef C_ARB_GRANT_CNT_EN
    req_vld = 4'b0001;
    step(70000);
    check("cnt_saturated", grant_cnt[15:0], 16'hFFFF);
`endif
    req_vld = 4'b0000;
    step(3);
    check("end_idle_vld", out_vld, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
